// File: rtl/hc_gate_pkg.sv
// Shared definitions for the full-bridge gate conditioning stage.
// Holds the per-leg state encoding, the per-leg command decode and the
// counter width/helpers used by dead_time_leg and mosfet_dead_time.
package hc_gate_pkg;

  localparam int unsigned CntW = 8;

  typedef logic [CntW-1:0] cnt_t;

  // Leg state; the encoding is visible on o_state.
  typedef enum logic [1:0] {
    StDead = 2'b00,
    StOnH  = 2'b01,
    StOnL  = 2'b10
  } leg_state_e;

  // Leg command, encoded as {high, low}.
  typedef enum logic [1:0] {
    CmdOff     = 2'b00,
    CmdLow     = 2'b01,
    CmdHigh    = 2'b10,
    CmdIllegal = 2'b11
  } leg_cmd_e;

  function automatic leg_cmd_e decode_cmd(input logic high, input logic low);
    return leg_cmd_e'({high, low});
  endfunction

  // Saturating increment; holds at all-ones.
  function automatic cnt_t sat_inc(input cnt_t v);
    return (v == '1) ? v : v + cnt_t'(1);
  endfunction

endpackage

// File: rtl/dead_time_leg.sv
// One half-bridge leg: state FSM with a dead-time counter and a min-on counter.
// Ports:
//   clk_i     clock
//   rst_i     synchronous active-high reset
//   cmd_i     decoded leg command (registered upstream)
//   kill_i    force DEAD now and block turn-on (fault, illegal, enable low)
//   state_o   current leg state
//   high_o    high-side gate
//   low_o     low-side gate
module dead_time_leg
  import hc_gate_pkg::*;
#(
  parameter cnt_t DeadTime = 8'd10,
  parameter cnt_t MinOn    = 8'd25
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  leg_cmd_e   cmd_i,
  input  logic       kill_i,
  output leg_state_e state_o,
  output logic       high_o,
  output logic       low_o
);

  leg_state_e state_q, state_d;
  cnt_t       dead_q, dead_d;
  cnt_t       on_q, on_d;

  // Counters load 1 on the edge a state is entered, so a count of N in a
  // cycle means the edge ending that cycle is N edges after entry.
  always_comb begin
    state_d = state_q;
    dead_d  = sat_inc(dead_q);
    on_d    = sat_inc(on_q);

    unique case (state_q)
      StDead: begin
        if (!kill_i && dead_q >= DeadTime) begin
          if (cmd_i == CmdHigh) begin
            state_d = StOnH;
          end else if (cmd_i == CmdLow) begin
            state_d = StOnL;
          end
        end
      end
      StOnH: begin
        if (kill_i || cmd_i == CmdOff || cmd_i == CmdIllegal) begin
          state_d = StDead;
        end else if (cmd_i == CmdLow && on_q >= MinOn) begin
          state_d = StDead;
        end
      end
      StOnL: begin
        if (kill_i || cmd_i == CmdOff || cmd_i == CmdIllegal) begin
          state_d = StDead;
        end else if (cmd_i == CmdHigh && on_q >= MinOn) begin
          state_d = StDead;
        end
      end
      default: state_d = StDead;
    endcase

    if (state_d != state_q) begin
      dead_d = cnt_t'(1);
      on_d   = cnt_t'(1);
    end
  end

  // The reset edge itself counts as DEAD entry.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StDead;
      dead_q  <= cnt_t'(1);
      on_q    <= '0;
    end else begin
      state_q <= state_d;
      dead_q  <= dead_d;
      on_q    <= on_d;
    end
  end

  assign state_o = state_q;
  assign high_o  = (state_q == StOnH);
  assign low_o   = (state_q == StOnL);

endmodule

// File: rtl/mosfet_dead_time.sv
// Full-bridge gate conditioning: registers the raw command, splits it into
// two legs with dead-time / min-on enforcement, and latches a sticky
// shoot-through fault.
// Ports:
//   i_clock    clock
//   i_RESET    synchronous active-high reset
//   i_enable   0 forces all gates off (not a fault)
//   i_MOSFET   raw command {B low, A low, B high, A high}
//   o_MOSFET   conditioned gates, same mapping
//   o_fault    sticky shoot-through fault
//   o_state    {legB_state, legA_state}
module mosfet_dead_time
  import hc_gate_pkg::*;
#(
  parameter logic [7:0] DEAD_TIME = 8'd10,
  parameter logic [7:0] MIN_ON    = 8'd25
) (
  input  logic       i_clock,
  input  logic       i_RESET,
  input  logic       i_enable,
  input  logic [3:0] i_MOSFET,
  output logic [3:0] o_MOSFET,
  output logic       o_fault,
  output logic [3:0] o_state
);

  logic [3:0] cmd_q;
  logic       en_q;
  logic       fault_q, fault_d;
  leg_cmd_e   cmd_a, cmd_b;
  logic       illegal, kill;
  leg_state_e state_a, state_b;
  logic       high_a, low_a, high_b, low_b;

  assign cmd_a   = decode_cmd(cmd_q[0], cmd_q[2]);
  assign cmd_b   = decode_cmd(cmd_q[1], cmd_q[3]);
  assign illegal = (cmd_a == CmdIllegal) || (cmd_b == CmdIllegal);
  // Illegal on either leg drops both legs on the same edge the fault sets.
  assign kill    = fault_q || illegal || !en_q;
  assign fault_d = fault_q || illegal;

  always_ff @(posedge i_clock) begin
    if (i_RESET) begin
      cmd_q   <= '0;
      en_q    <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      cmd_q   <= i_MOSFET;
      en_q    <= i_enable;
      fault_q <= fault_d;
    end
  end

  dead_time_leg #(
    .DeadTime (DEAD_TIME),
    .MinOn    (MIN_ON)
  ) u_leg_a (
    .clk_i   (i_clock),
    .rst_i   (i_RESET),
    .cmd_i   (cmd_a),
    .kill_i  (kill),
    .state_o (state_a),
    .high_o  (high_a),
    .low_o   (low_a)
  );

  dead_time_leg #(
    .DeadTime (DEAD_TIME),
    .MinOn    (MIN_ON)
  ) u_leg_b (
    .clk_i   (i_clock),
    .rst_i   (i_RESET),
    .cmd_i   (cmd_b),
    .kill_i  (kill),
    .state_o (state_b),
    .high_o  (high_b),
    .low_o   (low_b)
  );

  assign o_MOSFET = {low_b, low_a, high_b, high_a};
  assign o_fault  = fault_q;
  assign o_state  = {state_b, state_a};

endmodule

// File: tb/tb_mosfet_dead_time.sv
// Directed bench for mosfet_dead_time with default parameters.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_mosfet_dead_time;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] cmd;
  logic [3:0] gates;
  logic       fault;
  logic [3:0] state;

  int unsigned n_vec;
  int unsigned n_err;

  mosfet_dead_time dut (
    .i_clock  (clk),
    .i_RESET  (rst),
    .i_enable (en),
    .i_MOSFET (cmd),
    .o_MOSFET (gates),
    .o_fault  (fault),
    .o_state  (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Returns just after the last reset edge R.
  task automatic do_reset(input logic [3:0] c);
    cmd = c;
    en  = 1'b1;
    rst = 1'b1;
    step(3);
    rst = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    en    = 1'b0;
    cmd   = 4'b0000;
    step(1);

    // 1: reset release, first turn-on at R+10
    do_reset(4'b1001);
    check("rst_gates", 8'(gates), 8'h00);
    check("rst_fault", 8'(fault), 8'h00);
    check("rst_state", 8'(state), 8'h00);
    for (int i = 1; i <= 9; i++) begin
      step(1);
      check("t1_dead", 8'(gates), 8'h00);
    end
    step(1);  // E = R+10
    check("t1_on", 8'(gates), 8'b1001);
    check("t1_state", 8'(state), 8'b1001);
    check("t1_fault", 8'(fault), 8'h00);

    // 3: leg A swap to LOW sampled at E+2, min-on holds until E+25
    step(1);
    cmd = 4'b1100;
    step(1);  // E+2
    step(22); // E+24
    check("t3_hold", 8'(gates), 8'b1001);
    step(1);  // E+25
    check("t3_off", 8'(gates), 8'b1000);
    step(9);  // E+34
    check("t3_dead", 8'(gates), 8'b1000);
    step(1);  // E+35
    check("t3_low", 8'(gates), 8'b1100);

    // 2: steady 1001 then swap both legs to 0110
    do_reset(4'b1001);
    step(10);
    step(100);
    check("t2_steady", 8'(gates), 8'b1001);
    cmd = 4'b0110;
    step(1);  // k
    check("t2_k", 8'(gates), 8'b1001);
    step(1);
    check("t2_k1", 8'(gates), 8'h00);
    step(9);
    check("t2_k10", 8'(gates), 8'h00);
    step(1);
    check("t2_k11", 8'(gates), 8'b0110);
    check("t2_state", 8'(state), 8'b0110);

    // 4: OFF during short on-time, then re-apply
    do_reset(4'b1001);
    step(10); // E
    step(2);
    cmd = 4'b0000;
    step(1);  // k = E+3
    step(1);
    check("t4_off", 8'(gates), 8'h00);
    step(3);
    cmd = 4'b1001;
    step(1);  // k+5
    step(5);
    check("t4_k10", 8'(gates), 8'h00);
    step(1);
    check("t4_k11", 8'(gates), 8'b1001);

    // 5: leg A illegal latches fault until reset
    cmd = 4'b0101;
    step(1);  // k
    check("t5_k_fault", 8'(fault), 8'h00);
    step(1);
    check("t5_gates", 8'(gates), 8'h00);
    check("t5_fault", 8'(fault), 8'h01);
    cmd = 4'b1001;
    step(200);
    check("t5_sticky_gates", 8'(gates), 8'h00);
    check("t5_sticky_fault", 8'(fault), 8'h01);
    check("t5_sticky_state", 8'(state), 8'h00);
    do_reset(4'b1001);
    check("t5_clr", 8'(fault), 8'h00);
    step(10);
    check("t5_reon", 8'(gates), 8'b1001);

    // 6: enable low forces off without fault
    en = 1'b0;
    step(1);  // k
    step(1);
    check("t6_off", 8'(gates), 8'h00);
    check("t6_fault", 8'(fault), 8'h00);
    step(10);
    en = 1'b1;
    step(1);  // j = k+12
    check("t6_j", 8'(gates), 8'h00);
    step(1);
    check("t6_on", 8'(gates), 8'b1001);

    // Leg B illegal also faults
    cmd = 4'b1010;
    step(2);
    check("t7_fault", 8'(fault), 8'h01);
    check("t7_gates", 8'(gates), 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
